// File: rtl/instr_pkg.sv
// instr_pkg: request op codes, instruction opcodes and field positions shared by the loader and the control unit.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_RTYPE, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI,
        OP_B, OP_BEQ, OP_BNE, OP_LB, OP_SB, OP_LW, OP_SW
    } req_op_e;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b100000;
    localparam logic [5:0] OPC_LI    = 6'b111000;
    localparam logic [5:0] OPC_LUI   = 6'b111001;
    localparam logic [5:0] OPC_ADDI  = 6'b110000;
    localparam logic [5:0] OPC_ANDI  = 6'b110010;
    localparam logic [5:0] OPC_ORI   = 6'b110011;
    localparam logic [5:0] OPC_B     = 6'b111111;
    localparam logic [5:0] OPC_BEQ   = 6'b000000;
    localparam logic [5:0] OPC_BNE   = 6'b000001;
    localparam logic [5:0] OPC_LB    = 6'b000011;
    localparam logic [5:0] OPC_SB    = 6'b000111;
    localparam logic [5:0] OPC_LW    = 6'b001111;
    localparam logic [5:0] OPC_SW    = 6'b011111;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RD_LSB  = 16;
    localparam int RT_LSB  = 11;

    localparam logic [1:0]  RTYPE_TAG = 2'b11;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign dout    = mem_q[rd_q[PW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[PW-1:0]] = din;
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: encodes mnemonic-level requests into 32-bit instructions and streams them into
// instruction memory from a programmable start address through a small FIFO.
module instr_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load_start,
    input  logic              load_end,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rt,
    input  logic [3:0]        req_func,
    input  logic [15:0]       req_imm,
    input  logic              IM_Ready,
    output logic              IM_WrEn,
    output logic [ADDR_W-1:0] IM_Addr,
    output logic [31:0]       IM_WrData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rd,
        input logic [4:0]  rt,
        input logic [3:0]  func,
        input logic [15:0] imm
    );
        logic [5:0]  opc;
        logic [31:0] low;
        case (op)
            OP_RTYPE: opc = OPC_RTYPE;
            OP_LI:    opc = OPC_LI;
            OP_LUI:   opc = OPC_LUI;
            OP_ADDI:  opc = OPC_ADDI;
            OP_ANDI:  opc = OPC_ANDI;
            OP_ORI:   opc = OPC_ORI;
            OP_B:     opc = OPC_B;
            OP_BEQ:   opc = OPC_BEQ;
            OP_BNE:   opc = OPC_BNE;
            OP_LB:    opc = OPC_LB;
            OP_SB:    opc = OPC_SB;
            OP_LW:    opc = OPC_LW;
            OP_SW:    opc = OPC_SW;
            default:  opc = 6'b0;
        endcase
        low = (op == OP_RTYPE) ? ((32'(rt) << RT_LSB) | 32'({RTYPE_TAG, func})) : 32'(imm);
        encode = (op == OP_NOP) ? NOP_WORD
               : (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rd) << RD_LSB) | low;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d, acc_q, acc_d;
    logic              done_q, done_d, err_q, err_d;
    logic              full, empty, accept, reject, push, pop;
    logic [31:0]       word, head;

    // A session holds at most 2^ADDR_W words; acc_q counts words already committed to the FIFO.
    assign reject    = (req_op > OP_SW)
                     || (req_op == OP_BEQ && req_rs == '0 && req_rd == '0 && req_imm == '0)
                     || (acc_q == CAP);
    assign pop       = !empty && IM_Ready;
    assign req_ready = (state_q == ACTIVE) && (!full || pop);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !reject;
    assign word      = encode(req_op, req_rs, req_rd, req_rt, req_func, req_imm);

    assign IM_WrEn   = pop;
    assign IM_WrData = head;
    assign IM_Addr   = addr_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (word),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = pop ? addr_q + 1'b1 : addr_q;
        count_d = (pop && count_q != CAP) ? count_q + 1'b1 : count_q;
        acc_d   = push ? acc_q + 1'b1 : acc_q;
        done_d  = 1'b0;
        err_d   = accept && reject;
        case (state_q)
            IDLE: if (load_start) begin
                state_d = ACTIVE;
                addr_d  = start_addr;
                count_d = '0;
                acc_d   = '0;
            end
            ACTIVE: state_d = load_end ? DRAIN : ACTIVE;
            DRAIN: if (empty) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed stimulus for instr_loader with a queue scoreboard
// fed by a spec-level reference model and drained by an independent write monitor.
module tb_instr_loader;

    localparam int AW = 8;

    logic          clk = 1'b0, Reset = 1'b0;
    logic          load_start = 1'b0, load_end = 1'b0, req_valid = 1'b0, IM_Ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [3:0]    req_op = '0, req_func = '0;
    logic [4:0]    req_rs = '0, req_rd = '0, req_rt = '0;
    logic [15:0]   req_imm = '0;
    logic          req_ready, IM_WrEn, busy, done, err;
    logic [AW-1:0] IM_Addr;
    logic [31:0]   IM_WrData;
    logic [AW:0]   count;

    instr_loader #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .Reset(Reset), .load_start(load_start), .load_end(load_end),
        .start_addr(start_addr), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rd(req_rd), .req_rt(req_rt),
        .req_func(req_func), .req_imm(req_imm), .IM_Ready(IM_Ready), .IM_WrEn(IM_WrEn),
        .IM_Addr(IM_Addr), .IM_WrData(IM_WrData), .busy(busy), .done(done), .err(err),
        .count(count)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;
    int          m_addr = 0, m_cnt = 0, err_exp = 0, err_seen = 0, done_seen = 0, sess_d0 = 0;
    bit          done_exp = 0;
    int          im_mode = 0;
    int          opc_tab[14] = '{0, 32, 56, 57, 48, 50, 51, 63, 0, 1, 3, 7, 15, 31};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int op, rs, rd, rt, func, imm);
        longint w;
        if (op == 0) return 32'h0;
        w = longint'(opc_tab[op]) * 67108864 + rs * 2097152 + rd * 65536
          + ((op == 1) ? rt * 2048 + 48 + func : imm);
        return w[31:0];
    endfunction

    task automatic model_req(input int op, rs, rd, rt, func, imm, output bit rej);
        logic [7:0] a;
        rej = op >= 14 || (op == 8 && rs == 0 && rd == 0 && imm == 0) || m_cnt == 256;
        if (rej) err_exp++;
        else begin
            a = m_addr[7:0];
            exp_q.push_back({a, ref_enc(op, rs, rd, rt, func, imm)});
            m_addr = (m_addr + 1) % 256;
            m_cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        IM_Ready = (im_mode == 2) ? ($urandom_range(0, 3) != 0) : (im_mode == 1);
    end

    always @(negedge clk) begin
        if (IM_WrEn) begin
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", IM_Addr, IM_WrData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(IM_Addr), 64'(mon_e[39:32]));
                chk("wr_data", 64'(IM_WrData), 64'(mon_e[31:0]));
            end
        end
        if (err) err_seen++;
        if (done) begin
            if (!done_exp) begin
                vecs++; errs++;
                $display("FAIL done_unexpected: got done=1 expected 0");
            end else begin
                chk("done_count", 64'(count), 64'(m_cnt));
                chk("done_drained", 64'(exp_q.size()), 64'd0);
            end
            done_exp = 0;
            done_seen++;
        end
    end

    task automatic send(input int op, rs, rd, rt, func, imm, input bit with_end);
        bit rej = 0, ok = 0;
        req_valid = 1; req_op = op[3:0]; req_rs = rs[4:0]; req_rd = rd[4:0];
        req_rt = rt[4:0]; req_func = func[3:0]; req_imm = imm[15:0];
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                model_req(op, rs, rd, rt, func, imm, rej);
                if (with_end) begin load_end = 1; done_exp = 1; end
            end
            @(posedge clk); #1;
        end
        req_valid = 0; load_end = 0;
        if (!ok) begin
            vecs++; errs++;
            $display("FAIL send_timeout: got req_ready=0 for 300 cycles expected accept");
        end else if (rej) begin
            @(negedge clk);
            chk("err_pulse", 64'(err), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_rand(input int op_lo, op_hi, input bit with_end);
        int rs = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
        int rd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
        int im = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535);
        send($urandom_range(op_lo, op_hi), rs, rd, $urandom_range(0, 31), $urandom_range(0, 15), im, with_end);
    endtask

    task automatic start_sess(input int a, input bit with_end);
        sess_d0 = done_seen;
        load_start = 1; start_addr = a[AW-1:0]; load_end = with_end;
        @(posedge clk); #1;
        load_start = 0; load_end = 0;
        m_addr = a; m_cnt = 0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000 && done_seen == sess_d0; c++) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_seen - sess_d0), 64'd1);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic end_sess();
        load_end = 1; done_exp = 1;
        @(posedge clk); #1;
        load_end = 0;
        wait_done();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        im_mode = 1;
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", 64'({busy, done, err, req_ready, IM_WrEn, IM_Addr, count, IM_WrData}), 64'd0);
        @(negedge clk) Reset = 1;
        @(posedge clk); #1;

        load_end = 1;
        @(posedge clk); #1;
        load_end = 0;
        @(posedge clk); #1;
        chk("idle_end_ignored", 64'(busy), 64'd0);

        start_sess(16, 0);
        send(4, 1, 2, 0, 0, 5, 0);
        end_sess();
        chk("addi_count", 64'(count), 64'd1);

        start_sess(0, 0);
        send(1, 3, 4, 5, 1, 0, 0);
        send(3, 0, 1, 0, 0, 16'hABCD, 0);
        end_sess();

        start_sess(64, 0);
        send(8, 0, 0, 0, 0, 0, 0);
        send(15, 1, 2, 3, 4, 5, 0);
        repeat (3) @(posedge clk); #1;
        chk("reject_count", 64'(count), 64'd0);
        chk("reject_errs", 64'(err_seen), 64'(err_exp));
        send(0, 7, 7, 7, 7, 7, 0);
        end_sess();

        im_mode = 0;
        @(posedge clk); #1;
        start_sess(128, 0);
        for (int i = 0; i < 4; i++) send_rand(1, 7, 0);
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready_full", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        im_mode = 1;
        send_rand(1, 7, 0);
        send_rand(1, 7, 0);
        end_sess();
        chk("bp_count", 64'(count), 64'd6);

        start_sess(32, 1);
        chk("start_wins", 64'(busy), 64'd1);
        load_start = 1; start_addr = 8'h99;
        @(posedge clk); #1;
        load_start = 0;
        send(2, 9, 10, 0, 0, 16'h1234, 0);
        send(13, 4, 5, 0, 0, 16'h00FF, 1);
        wait_done();

        im_mode = 0;
        @(posedge clk); #1;
        start_sess(48, 0);
        send(5, 1, 1, 0, 0, 1, 0);
        send(6, 2, 2, 0, 0, 2, 0);
        load_end = 1;
        @(posedge clk); #1;
        load_end = 0;
        @(posedge clk); #1;
        chk("drain_busy", 64'(busy), 64'd1);
        Reset = 0;
        #1;
        chk("abort_outputs", 64'({busy, done, err, req_ready, IM_WrEn, IM_Addr, count, IM_WrData}), 64'd0);
        exp_q.delete();
        m_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) Reset = 1;
        im_mode = 1;
        repeat (4) @(posedge clk); #1;
        chk("post_reset_idle", 64'({busy, count}), 64'd0);
        start_sess(16, 0);
        send(4, 1, 2, 0, 0, 5, 0);
        end_sess();
        chk("clean_session_count", 64'(count), 64'd1);

        im_mode = 2;
        for (int s = 0; s < 5; s++) begin
            int  n = $urandom_range(5, 25);
            bit  e = $urandom_range(0, 1) == 1;
            start_sess($urandom_range(0, 255), 0);
            for (int i = 0; i < n; i++) send_rand(0, 15, e && i == n - 1);
            if (e) wait_done();
            else end_sess();
        end

        start_sess(253, 0);
        for (int i = 0; i < 260; i++) send_rand(1, 7, 0);
        end_sess();
        chk("sat_count", 64'(count), 64'd256);
        chk("err_total", 64'(err_seen), 64'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
